univ_shift_reg: RTL
===================

Name: univ_shift_reg

Overview:
Parametrised universal shift register. Supports parallel load, single-step shifting, and counted burst shifting in either direction, with fill or rotate. Burst operation uses a start/busy/done handshake so a controller can request N shifts and wait for completion. Used as a serialiser/deserialiser and bit-manipulation element in lab datapaths.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), width of burst length/counter (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load  input  1  parallel load strobe (highest priority)
parallel_in  input  WIDTH  parallel load data
shift_en  input  1  single-step shift request (idle only)
dir  input  1  0 = left (toward MSB), 1 = right (toward LSB)
rotate  input  1  1 = rotate, 0 = fill vacated bit with serial_in
serial_in  input  1  fill bit when rotate=0
start  input  1  burst request (idle only)
burst_len  input  CNT_W  number of shifts in burst
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion
shift_out_msb  output  1  reg[WIDTH-1]
shift_out_lsb  output  1  reg[0]
reg_content  output  WIDTH  current register value

Behaviour:
- Reset (rst_n low, asynchronous, immediate): reg_content=0, busy=0, done=0, counter=0, FSM=IDLE. Reset mid-burst aborts the burst with no done pulse.
- Shift step, left: reg <= {reg[W-2:0], rotate ? reg[W-1] : serial_in}.
- Shift step, right: reg <= {rotate ? reg[0] : serial_in, reg[W-1:1]}.
- shift_out_msb and shift_out_lsb are combinational from reg.
- FSM states: IDLE, SHIFT, DONE. busy=1 only in SHIFT. done=1 only in DONE.
- Priority at each edge: load > start > shift_en. Load applies in every state.
- IDLE or DONE, load=1: reg <= parallel_in; next state IDLE.
- IDLE or DONE, start=1, burst_len=0: reg unchanged; next state DONE.
- IDLE or DONE, start=1, burst_len>0: latch dir and rotate into burst registers; cnt <= burst_len; next state SHIFT. No shift on this edge.
- IDLE or DONE, shift_en=1 (no load, no start): one step using live dir, rotate and serial_in. Zero latency: new value visible after this edge. State -> IDLE.
- SHIFT: each edge performs one step using the latched dir/rotate and the live serial_in, then cnt <= cnt-1.
  - When cnt==1, that edge's step is the last one; next state DONE.
  - Exactly burst_len steps occur. Values above WIDTH are legal; they keep shifting or rotating.
- SHIFT, load=1: reg <= parallel_in; burst aborted; next state IDLE; no done pulse; cnt cleared.
- SHIFT: start and shift_en are ignored. burst_len, dir and rotate changes have no effect on the current burst.
- DONE lasts exactly one cycle, then IDLE, unless a new start, load or shift_en is accepted in that cycle.
- Timing: start accepted at edge E0 → busy high E0..EN → shifts at E1..EN → done high between EN and EN+1.

Decomposition:
- Package shift_pkg:
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1
  - FSM state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
- One sub-module: shift_step. Purely combinational next-value function (reg, dir, rotate, serial_in → next reg), parameterised by WIDTH. It is shared by the single-step and burst paths.
- FSM, counter and register live in univ_shift_reg.

Test Plan:
- Async reset (WIDTH=8): drop rst_n mid-burst, between clock edges -> reg_content=0x00, busy=0, done=0 immediately; no done pulse after release.
- Single step: load 0xA5, then shift_en with dir=0, rotate=0, serial_in=1 -> 0x4B. Then dir=1, rotate=1 -> 0xA5. shift_out_msb/shift_out_lsb track reg bits 7/0.
- Burst rotate: load 0x81; start, burst_len=3, dir=1, rotate=1 -> sequence 0xC0, 0x60, 0x30. busy high for exactly E0..E3, done pulse for one cycle after E3. Toggling dir during the burst has no effect.
- Zero-length burst: start with burst_len=0 -> no busy, done pulses the following cycle, reg unchanged.
- Abort and priority: load 0x0F mid-burst -> reg=0x0F, busy=0 next cycle, no done. Load and shift_en in the same cycle -> load wins. start or shift_en while busy -> ignored, count unaffected.
- Long burst: load 0x01, burst_len=8 (WIDTH), left rotate -> reg returns to 0x01 with exactly one done pulse. burst_len=9 with rotate=0, serial_in=0 -> 0x00.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants for the universal shift register: shift direction
// encoding and the burst-control FSM state type.
package shift_pkg;

    localparam logic DIR_LEFT  = 1'b0;  // toward MSB
    localparam logic DIR_RIGHT = 1'b1;  // toward LSB

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// One shift step of the register: computes the next register value from
// the current one, the direction, the rotate/fill choice and the serial
// fill bit. Purely combinational; shared by single-step and burst paths.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] reg_i,
    input  logic             dir_i,
    input  logic             rotate_i,
    input  logic             serial_in_i,
    output logic [WIDTH-1:0] next_o
);

    // Select the bit entering the vacated end, then splice it in.
    always_comb begin
        next_o = reg_i;
        unique case (dir_i)
            DIR_LEFT:  next_o = {reg_i[WIDTH-2:0], rotate_i ? reg_i[WIDTH-1] : serial_in_i};
            DIR_RIGHT: next_o = {rotate_i ? reg_i[0] : serial_in_i, reg_i[WIDTH-1:1]};
        endcase
    end

endmodule : shift_step

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, single-step shift and counted
// burst shift (left/right, fill/rotate) with a start/busy/done handshake.
// Load always wins; a load during a burst aborts it without a done pulse.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             rotate,
    input  logic             serial_in,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             shift_out_msb,
    output logic             shift_out_lsb,
    output logic [WIDTH-1:0] reg_content
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   reg_q,   reg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               bdir_q,  bdir_d;
    logic               brot_q,  brot_d;

    logic               step_dir;
    logic               step_rot;
    logic [WIDTH-1:0]   step_val;

    // During a burst the step uses the direction/mode captured at start;
    // otherwise it follows the live inputs.
    assign step_dir = (state_q == SHIFT) ? bdir_q : dir;
    assign step_rot = (state_q == SHIFT) ? brot_q : rotate;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .reg_i       (reg_q),
        .dir_i       (step_dir),
        .rotate_i    (step_rot),
        .serial_in_i (serial_in),
        .next_o      (step_val)
    );

    // Next-state, next-register and counter logic with priority load > start > shift_en.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case can leave it unassigned and infer a latch.
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        bdir_d  = bdir_q;
        brot_d  = brot_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (load) begin
                    reg_d = parallel_in;
                    cnt_d = '0;
                end else if (start) begin
                    if (burst_len == '0) begin
                        state_d = DONE;
                    end else begin
                        bdir_d  = dir;
                        brot_d  = rotate;
                        cnt_d   = burst_len;
                        state_d = SHIFT;
                    end
                end else if (shift_en) begin
                    reg_d = step_val;
                end
            end

            SHIFT: begin
                if (load) begin
                    reg_d   = parallel_in;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    reg_d = step_val;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, data, counter and captured burst-mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            bdir_q  <= DIR_LEFT;
            brot_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values,
            // independent of statement order.
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            bdir_q  <= bdir_d;
            brot_q  <= brot_d;
        end
    end

    assign busy          = (state_q == SHIFT);
    assign done          = (state_q == DONE);
    assign reg_content   = reg_q;
    assign shift_out_msb = reg_q[WIDTH-1];
    assign shift_out_lsb = reg_q[0];

endmodule : univ_shift_reg
